// File: rtl/pad_cfg_pkg.sv
// Shared types for the pad configuration sequencer: per-pad config byte,
// the safe (all-disabled) value and the apply-sequence state encoding.
package pad_cfg_pkg;

    // Bit 7..0 = {SR, PS, PE, IS, IE, OE, DS1, DS0}
    typedef struct packed {
        logic sr;
        logic ps;
        logic pe;
        logic is;
        logic ie;
        logic oe;
        logic ds1;
        logic ds0;
    } pad_cfg_t;

    // Output and input buffers disabled, no pull, minimum drive
    localparam pad_cfg_t PadCfgSafe = '0;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSettle
    } pad_seq_state_e;

    // $clog2 with a floor of one bit, for counters and indices
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/pad_cfg_regfile.sv
// Shadow configuration storage and its request/grant access port.
// Reads are always granted; writes only while the sequencer allows them.
// Out-of-range writes are granted and dropped, out-of-range reads return 0.
module pad_cfg_regfile
    import pad_cfg_pkg::*;
#(
    parameter int unsigned NumPads = 16,
    localparam int unsigned AddrW  = clog2_min1(NumPads)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wr_allow_i,
    input  logic                      wr_drop_i,
    input  logic                      cfg_req_i,
    input  logic                      cfg_we_i,
    input  logic [AddrW-1:0]          cfg_addr_i,
    input  logic [7:0]                cfg_wdata_i,
    output logic                      cfg_gnt_o,
    output logic                      cfg_rvalid_o,
    output logic [7:0]                cfg_rdata_o,
    output pad_cfg_t [NumPads-1:0]    shadow_o
);

    localparam logic [AddrW:0] NumPadsL = (AddrW + 1)'(NumPads);

    pad_cfg_t [NumPads-1:0] shadow_q;
    pad_cfg_t               rdata_q;
    logic                   rvalid_q;
    logic                   in_range;
    logic                   wr_en;
    logic                   rd_en;

    assign in_range  = ({1'b0, cfg_addr_i} < NumPadsL);
    assign cfg_gnt_o = cfg_req_i && (!cfg_we_i || wr_allow_i);
    assign wr_en     = cfg_gnt_o && cfg_we_i && in_range && !wr_drop_i;
    assign rd_en     = cfg_gnt_o && !cfg_we_i;

    // Shadow writes and the one-cycle-latency read return
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= {NumPads{PadCfgSafe}};
            rvalid_q <= 1'b0;
            rdata_q  <= PadCfgSafe;
        end else begin
            if (wr_en) begin
                shadow_q[cfg_addr_i] <= pad_cfg_t'(cfg_wdata_i);
            end
            rvalid_q <= rd_en;
            rdata_q  <= (rd_en && in_range) ? shadow_q[cfg_addr_i] : PadCfgSafe;
        end
    end

    assign cfg_rvalid_o = rvalid_q;
    assign cfg_rdata_o  = rdata_q;
    assign shadow_o     = shadow_q;

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Pad ring configuration controller: applies the shadow configuration to
// the live pad controls one group at a time with a settle gap between
// groups, limiting simultaneous switching on the ring.
// Optional feature: define PAD_CFG_LOCK_EN to add lock_i, a sticky lock
// that drops writes and ignores commits until reset.
module pad_cfg_sequencer
    import pad_cfg_pkg::*;
#(
    parameter int unsigned NumPads      = 16,
    parameter int unsigned GroupSize    = 4,
    parameter int unsigned SettleCycles = 8,
    localparam int unsigned AddrW       = clog2_min1(NumPads)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_req_i,
    input  logic               cfg_we_i,
    input  logic [AddrW-1:0]   cfg_addr_i,
    input  logic [7:0]         cfg_wdata_i,
    output logic               cfg_gnt_o,
    output logic               cfg_rvalid_o,
    output logic [7:0]         cfg_rdata_o,
    input  logic               commit_i,
`ifdef PAD_CFG_LOCK_EN
    input  logic               lock_i,
`endif
    output logic               busy_o,
    output logic               done_o,
    output logic [NumPads-1:0] pad_ds0_o,
    output logic [NumPads-1:0] pad_ds1_o,
    output logic [NumPads-1:0] pad_ie_o,
    output logic [NumPads-1:0] pad_is_o,
    output logic [NumPads-1:0] pad_oe_o,
    output logic [NumPads-1:0] pad_pe_o,
    output logic [NumPads-1:0] pad_ps_o,
    output logic [NumPads-1:0] pad_sr_o
);

    localparam int unsigned     NumGroups = (NumPads + GroupSize - 1) / GroupSize;
    localparam int unsigned     GrpW      = clog2_min1(NumGroups);
    localparam int unsigned     CntW      = clog2_min1(SettleCycles);
    localparam logic [GrpW-1:0] LastGrp   = GrpW'(NumGroups - 1);
    localparam logic [CntW-1:0] CntInit   = (SettleCycles > 0) ? CntW'(SettleCycles - 1) : '0;

    pad_seq_state_e         state_q;
    logic [GrpW-1:0]        grp_q;
    logic [CntW-1:0]        cnt_q;
    logic                   pending_q;
    logic                   busy_q;
    logic                   done_q;
    pad_cfg_t [NumPads-1:0] live_q;
    pad_cfg_t [NumPads-1:0] shadow;
    logic                   locked;

`ifdef PAD_CFG_LOCK_EN
    logic locked_q;

    // Sticky lock, released only by reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q <= 1'b0;
        end else if (lock_i) begin
            locked_q <= 1'b1;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    pad_cfg_regfile #(
        .NumPads (NumPads)
    ) u_regfile (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_allow_i   (state_q == StIdle),
        .wr_drop_i    (locked),
        .cfg_req_i    (cfg_req_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_gnt_o    (cfg_gnt_o),
        .cfg_rvalid_o (cfg_rvalid_o),
        .cfg_rdata_o  (cfg_rdata_o),
        .shadow_o     (shadow)
    );

    // Apply sequencer: group copy, settle countdown, pending re-run, status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            grp_q     <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            live_q    <= {NumPads{PadCfgSafe}};
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!locked && (commit_i || pending_q)) begin
                        state_q   <= StApply;
                        busy_q    <= 1'b1;
                        grp_q     <= '0;
                        pending_q <= 1'b0;
                    end
                end
                StApply: begin
                    for (int unsigned i = 0; i < NumPads; i++) begin
                        if (GrpW'(i / GroupSize) == grp_q) begin
                            live_q[i] <= shadow[i];
                        end
                    end
                    if (commit_i && !locked) begin
                        pending_q <= 1'b1;
                    end
                    if (SettleCycles > 0) begin
                        cnt_q   <= CntInit;
                        state_q <= StSettle;
                    end else if (grp_q == LastGrp) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        grp_q <= grp_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (commit_i && !locked) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        if (grp_q == LastGrp) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            grp_q   <= grp_q + 1'b1;
                            state_q <= StApply;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

    // Pad control pins are plain bit slices of the live registers
    always_comb begin
        pad_ds0_o = '0;
        pad_ds1_o = '0;
        pad_ie_o  = '0;
        pad_is_o  = '0;
        pad_oe_o  = '0;
        pad_pe_o  = '0;
        pad_ps_o  = '0;
        pad_sr_o  = '0;
        for (int unsigned i = 0; i < NumPads; i++) begin
            pad_ds0_o[i] = live_q[i].ds0;
            pad_ds1_o[i] = live_q[i].ds1;
            pad_ie_o[i]  = live_q[i].ie;
            pad_is_o[i]  = live_q[i].is;
            pad_oe_o[i]  = live_q[i].oe;
            pad_pe_o[i]  = live_q[i].pe;
            pad_ps_o[i]  = live_q[i].ps;
            pad_sr_o[i]  = live_q[i].sr;
        end
    end

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: default build (16 pads, groups of 4,
// 8 settle cycles) plus a small no-settle instance with a partial group and
// out-of-range addresses. Lock behaviour is exercised when PAD_CFG_LOCK_EN
// is defined.
module tb_pad_cfg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, commit = 1'b0, lock = 1'b0;
    logic [3:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic        gnt, rvalid, busy, done;
    logic [7:0]  rdata;
    logic [15:0] pad_ds0, pad_ds1, pad_ie, pad_is, pad_oe, pad_pe, pad_ps, pad_sr;

    logic        s_req = 1'b0, s_we = 1'b0, s_commit = 1'b0, s_lock = 1'b0;
    logic [2:0]  s_addr = '0;
    logic [7:0]  s_wdata = '0;
    logic        s_gnt, s_rvalid, s_busy, s_done;
    logic [7:0]  s_rdata;
    logic [5:0]  s_ds0, s_ds1, s_ie, s_is, s_oe, s_pe, s_ps, s_sr;

    pad_cfg_sequencer u_dut (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(req), .cfg_we_i(we), .cfg_addr_i(addr),
        .cfg_wdata_i(wdata), .cfg_gnt_o(gnt), .cfg_rvalid_o(rvalid), .cfg_rdata_o(rdata),
        .commit_i(commit),
`ifdef PAD_CFG_LOCK_EN
        .lock_i(lock),
`endif
        .busy_o(busy), .done_o(done),
        .pad_ds0_o(pad_ds0), .pad_ds1_o(pad_ds1), .pad_ie_o(pad_ie), .pad_is_o(pad_is),
        .pad_oe_o(pad_oe), .pad_pe_o(pad_pe), .pad_ps_o(pad_ps), .pad_sr_o(pad_sr)
    );

    pad_cfg_sequencer #(.NumPads(6), .GroupSize(4), .SettleCycles(0)) u_dut_small (
        .clk_i(clk), .rst_i(rst), .cfg_req_i(s_req), .cfg_we_i(s_we), .cfg_addr_i(s_addr),
        .cfg_wdata_i(s_wdata), .cfg_gnt_o(s_gnt), .cfg_rvalid_o(s_rvalid),
        .cfg_rdata_o(s_rdata), .commit_i(s_commit),
`ifdef PAD_CFG_LOCK_EN
        .lock_i(s_lock),
`endif
        .busy_o(s_busy), .done_o(s_done),
        .pad_ds0_o(s_ds0), .pad_ds1_o(s_ds1), .pad_ie_o(s_ie), .pad_is_o(s_is),
        .pad_oe_o(s_oe), .pad_pe_o(s_pe), .pad_ps_o(s_ps), .pad_sr_o(s_sr)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[11];
    logic       prev_rd;
    logic [7:0] prev_exp;
    logic       granted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pads_zero(input string name);
        check(name, {16'h0, pad_ds0 | pad_ds1 | pad_ie | pad_is | pad_oe | pad_pe | pad_ps
                     | pad_sr}, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        check("wr_gnt", {31'h0, gnt}, 32'h1);
        step();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        check("rd_gnt", {31'h0, gnt}, 32'h1);
        step();
        req = 1'b0;
        @(negedge clk);
        check("rd_rvalid", {31'h0, rvalid}, 32'h1);
        check("rd_rdata", {24'h0, rdata}, {24'h0, exp});
        step();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd5,  8'h0C, 8'h00};
        vecs[1]  = '{1'b1, 4'd0,  8'hA5, 8'h00};
        vecs[2]  = '{1'b1, 4'd15, 8'hFF, 8'h00};
        vecs[3]  = '{1'b0, 4'd5,  8'h00, 8'h0C};
        vecs[4]  = '{1'b1, 4'd3,  8'h3C, 8'h00};
        vecs[5]  = '{1'b0, 4'd3,  8'h00, 8'h3C};
        vecs[6]  = '{1'b0, 4'd0,  8'h00, 8'hA5};
        vecs[7]  = '{1'b0, 4'd15, 8'h00, 8'hFF};
        vecs[8]  = '{1'b0, 4'd7,  8'h00, 8'h00};
        vecs[9]  = '{1'b1, 4'd3,  8'h5A, 8'h00};
        vecs[10] = '{1'b0, 4'd3,  8'h00, 8'h5A};

        // Reset state
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_gnt", {31'h0, gnt}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_rdata", {24'h0, rdata}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check_pads_zero("rst_pads");
        step();
        rd(4'd3, 8'h00);

        // Back-to-back access vectors
        prev_rd = 1'b0;
        prev_exp = 8'h00;
        for (int i = 0; i < 11; i++) begin
            req = 1'b1; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            @(negedge clk);
            check("vec_gnt", {31'h0, gnt}, 32'h1);
            check("vec_rvalid", {31'h0, rvalid}, {31'h0, prev_rd});
            if (prev_rd) check("vec_rdata", {24'h0, rdata}, {24'h0, prev_exp});
            else check("vec_rdata_idle", {24'h0, rdata}, 32'h0);
            prev_rd = !vecs[i].we;
            prev_exp = vecs[i].exp;
            step();
        end
        req = 1'b0; we = 1'b0;
        @(negedge clk);
        check("vec_last_rvalid", {31'h0, rvalid}, {31'h0, prev_rd});
        check("vec_last_rdata", {24'h0, rdata}, {24'h0, prev_exp});
        check_pads_zero("vec_pads_untouched");
        step();

        // Single pass with a write stalled until the done cycle
        commit = 1'b1; step(); commit = 1'b0;
        granted = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c >= 20 && !granted) begin
                req = 1'b1; we = 1'b1; addr = 4'd1; wdata = 8'h11;
            end else begin
                req = 1'b0; we = 1'b0;
            end
            @(negedge clk);
            check("p1_busy", {31'h0, busy}, {31'h0, c <= 36});
            check("p1_done", {31'h0, done}, {31'h0, c == 37});
            check("p1_oe5", {31'h0, pad_oe[5]}, {31'h0, c >= 11});
            check("p1_ie5", {31'h0, pad_ie[5]}, {31'h0, c >= 11});
            check("p1_oe4", {31'h0, pad_oe[4]}, 32'h0);
            check("p1_ds0_0", {31'h0, pad_ds0[0]}, {31'h0, c >= 2});
            check("p1_sr15", {31'h0, pad_sr[15]}, {31'h0, c >= 29});
            if (req) begin
                check("p1_busy_gnt", {31'h0, gnt}, {31'h0, c == 37});
                if (gnt) granted = 1'b1;
            end
            step();
        end
        req = 1'b0; we = 1'b0;
        check("p1_granted", {31'h0, granted}, 32'h1);
        check("p1_pad1_live", {30'h0, pad_is[1], pad_ds0[1]}, 32'h0);
        rd(4'd1, 8'h11);

        // Commit while busy: one extra pass, back to back
        commit = 1'b1; step(); commit = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            commit = (c == 5);
            @(negedge clk);
            check("p2_busy", {31'h0, busy}, {31'h0, (c <= 36) || (c >= 38 && c <= 73)});
            check("p2_done", {31'h0, done}, {31'h0, (c == 37) || (c == 74)});
            check("p2_is1", {31'h0, pad_is[1]}, {31'h0, c >= 2});
            step();
        end
        commit = 1'b0;

        // Synchronous reset mid-pass with a pending re-run queued
        commit = 1'b1; step(); commit = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            commit = (c == 5);
            rst = (c == 15);
            @(negedge clk);
            check("r_busy_pre", {31'h0, busy}, 32'h1);
            if (c == 15) check("r_oe5_pre", {31'h0, pad_oe[5]}, 32'h1);
            step();
        end
        rst = 1'b0; commit = 1'b0;
        @(negedge clk);
        check_pads_zero("r_pads");
        check("r_busy", {31'h0, busy}, 32'h0);
        check("r_done", {31'h0, done}, 32'h0);
        step();
        for (int c = 17; c <= 60; c++) begin
            @(negedge clk);
            if (busy || done) check("r_no_rerun", {30'h0, busy, done}, 32'h0);
            step();
        end
        check("r_idle_final", {31'h0, busy}, 32'h0);
        rd(4'd5, 8'h00);

        // Small instance: out-of-range access, partial group, no settle
        s_req = 1'b1; s_we = 1'b1; s_addr = 3'd5; s_wdata = 8'h04;
        @(negedge clk);
        check("s_wr_gnt", {31'h0, s_gnt}, 32'h1);
        step();
        s_addr = 3'd7; s_wdata = 8'hFF;
        @(negedge clk);
        check("s_oor_wr_gnt", {31'h0, s_gnt}, 32'h1);
        step();
        s_we = 1'b0; s_addr = 3'd7;
        @(negedge clk);
        check("s_oor_rd_gnt", {31'h0, s_gnt}, 32'h1);
        step();
        s_addr = 3'd5;
        @(negedge clk);
        check("s_oor_rvalid", {31'h0, s_rvalid}, 32'h1);
        check("s_oor_rdata", {24'h0, s_rdata}, 32'h0);
        step();
        s_req = 1'b0;
        @(negedge clk);
        check("s_rd5_rdata", {24'h0, s_rdata}, 32'h04);
        step();
        s_commit = 1'b1; step(); s_commit = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("s_busy", {31'h0, s_busy}, {31'h0, c <= 2});
            check("s_done", {31'h0, s_done}, {31'h0, c == 3});
            check("s_oe5", {31'h0, s_oe[5]}, {31'h0, c >= 3});
            step();
        end

`ifdef PAD_CFG_LOCK_EN
        // Locked: writes dropped, commits ignored
        lock = 1'b1; step(); lock = 1'b0;
        wr(4'd0, 8'hFF);
        rd(4'd0, 8'h00);
        commit = 1'b1; step(); commit = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("l_busy", {31'h0, busy}, 32'h0);
            check_pads_zero("l_pads");
            step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
